// File: rtl/sa_ram_rws_param.sv
// -----------------------------------------------------------------------------
// sa_ram_rws_param
//
// Purpose:
//   Single-clock RAM with one read port and one write port (DEPTH x WIDTH).
//   After every reset the control FSM sweeps the whole array and writes zero
//   to each word. This takes exactly DEPTH cycles. While the sweep runs, user
//   reads and writes are ignored. Read data is registered, and can optionally
//   pass through one more pipeline stage (OUT_REG = 1).
//
// Parameters:
//   WIDTH   - data width in bits
//   DEPTH   - number of words (2..4096, need not be a power of two)
//   AW      - address width, must satisfy ceil(log2(DEPTH)) <= AW
//   OUT_REG - number of extra output pipeline stages (0 or 1)
//
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   rstn          - synchronous active-low reset
//   ra, re        - read address / read enable
//   dout, rd_vld  - registered read data / one-cycle valid pulse
//   wa, we, di    - write address / write enable / write data
//   init_done     - high once the zeroing sweep has finished
//   pwrbus_ram_pd - power-down bus, accepted but has no functional effect
//
// Configuration macro:
//   SA_RAM_WRITE_BYPASS_EN - when defined, a read and a write to the same
//   in-range address in the same cycle return the new write data
//   (write-first). When undefined, the read returns the old contents
//   (read-first). This macro changes nothing else.
// -----------------------------------------------------------------------------
module sa_ram_rws_param #(
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             rd_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    output logic             init_done,
    input  logic [31:0]      pwrbus_ram_pd
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Range limit is one bit wider than the address, so that DEPTH == 2**AW
    // still fits in the constant.
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [AW-1:0]      init_cnt_r;
    logic               init_done_r;

    logic [WIDTH-1:0]   mem_r [DEPTH];

    logic               mem_we_s;
    logic [AW-1:0]      mem_wa_s;
    logic [WIDTH-1:0]   mem_wd_s;
    logic               rd_en_s;

    logic               ra_in_range_s;
    logic               wa_in_range_s;
    logic [WIDTH-1:0]   rd_word_s;

    logic [WIDTH-1:0]   rd_data_r;
    logic               rd_vld1_r;

    // The power-down bus is only reduced into a sink net. It must never
    // influence behaviour.
    logic               pwrbus_unused_s;
    assign pwrbus_unused_s = ^pwrbus_ram_pd;

    assign ra_in_range_s = ({1'b0, ra} < DEPTH_LIM);
    assign wa_in_range_s = ({1'b0, wa} < DEPTH_LIM);

    // State register: FSM state, sweep counter and the registered init_done flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            init_done_r <= (state_nxt_s == ST_READY);
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + AW'(1);
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Next-state logic: leave INIT right after the last word is cleared. READY is then held until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // Output decode: while INIT runs, the sweep owns the write port and user traffic is ignored.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = '0;
        mem_wd_s = '0;
        rd_en_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                mem_we_s = 1'b1;
                mem_wa_s = init_cnt_r;
                mem_wd_s = '0;
                rd_en_s  = 1'b0;
            end
            ST_READY: begin
                mem_we_s = we & wa_in_range_s;
                mem_wa_s = wa;
                mem_wd_s = di;
                rd_en_s  = re;
            end
            default: begin
                mem_we_s = 1'b0;
                mem_wa_s = '0;
                mem_wd_s = '0;
                rd_en_s  = 1'b0;
            end
        endcase
    end

    // Storage write port. The array itself is not reset. It is cleared only by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rstn && mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Read word selection: out-of-range reads return zero, and the collision policy is chosen at build time.
    always_comb begin
        rd_word_s = '0;
        if (ra_in_range_s) begin
`ifdef SA_RAM_WRITE_BYPASS_EN
            if (we && (wa == ra)) begin
                rd_word_s = di;
            end else begin
                rd_word_s = mem_r[ra];
            end
`else
            rd_word_s = mem_r[ra];
`endif
        end else begin
            rd_word_s = '0;
        end
    end

    // First read stage: capture the data on a read, and otherwise hold the last value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_r <= '0;
            rd_vld1_r <= 1'b0;
        end else begin
            rd_vld1_r <= rd_en_s;
            if (rd_en_s) begin
                rd_data_r <= rd_word_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] dout_r;
            logic             rd_vld2_r;

            // Optional output stage: data moves forward only with its valid, so dout holds between reads.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dout_r    <= '0;
                    rd_vld2_r <= 1'b0;
                end else begin
                    rd_vld2_r <= rd_vld1_r;
                    if (rd_vld1_r) begin
                        dout_r <= rd_data_r;
                    end else begin
                        dout_r <= dout_r;
                    end
                end
            end

            assign dout   = dout_r;
            assign rd_vld = rd_vld2_r;
        end else begin : g_no_out_reg
            assign dout   = rd_data_r;
            assign rd_vld = rd_vld1_r;
        end
    endgenerate

    assign init_done = init_done_r;

endmodule

// File: doc/sa_ram_rws_param.md
SA_RAM_RWS_PARAM -- requirements
Module: sa_ram_rws_param

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 64, meaning data width in bits.
- REQ-002: The block SHALL have parameter DEPTH, default 64, meaning number of words; any value 2..4096 is legal, including non-power-of-2.
- REQ-003: The block SHALL have parameter AW, default 6, meaning address width; ceil(log2(DEPTH)) <= AW is required.
- REQ-004: The block SHALL have parameter OUT_REG, default 0, meaning the number of extra output pipeline stages (0 or 1).
- REQ-005: The block SHALL use one clock; reset SHALL be synchronous and active-low.
- REQ-006: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-007: Port rstn, input, 1 bit: synchronous active-low reset.
- REQ-008: Port ra, input, AW bits: read address.
- REQ-009: Port re, input, 1 bit: read enable.
- REQ-010: Port dout, output, WIDTH bits: registered read data.
- REQ-011: Port rd_vld, output, 1 bit: one-cycle pulse marking dout as valid for a read.
- REQ-012: Port wa, input, AW bits: write address.
- REQ-013: Port we, input, 1 bit: write enable.
- REQ-014: Port di, input, WIDTH bits: write data.
- REQ-015: Port init_done, output, 1 bit: high once the memory clear has completed.
- REQ-016: Port pwrbus_ram_pd, input, 32 bits: power-down bus; accepted and SHALL have no functional effect.

Function
- REQ-017: Storage SHALL be a DEPTH x WIDTH array with one read port and one write port, usable in the same cycle.
- REQ-018: The control FSM SHALL have two states: INIT, entered on reset, and READY.
- REQ-019: In INIT, each cycle SHALL write zero to M[init_cnt] and increment init_cnt from 0.
- REQ-020: The FSM SHALL move from INIT to READY in the cycle after init_cnt = DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
- REQ-021: READY SHALL be held until the next reset.
- REQ-022: init_done SHALL be 0 in INIT and 1 in READY.
- REQ-023: In INIT, re and we SHALL be ignored: no write, no rd_vld, dout unchanged.
- REQ-024: In READY, when we=1 and wa < DEPTH, M[wa] SHALL be updated with di at the clock edge.
- REQ-025: A write with wa >= DEPTH SHALL be dropped.
- REQ-026: In READY, re=1 SHALL capture M[ra] into the read-data register at the edge.
- REQ-027: Read latency SHALL be 1 + OUT_REG cycles from re to dout/rd_vld.
- REQ-028: A read with ra >= DEPTH SHALL return all zeros, with rd_vld still asserted.
- REQ-029: rd_vld SHALL follow re through the same pipeline depth as the data; back-to-back reads SHALL be supported every cycle.
- REQ-030: dout SHALL hold its last value while no new read completes; it SHALL NOT return to zero.
- REQ-031: A same-cycle read and write to the same address SHALL follow REQ-043 / REQ-044.
- REQ-032: Reads and writes to different addresses SHALL be fully independent.

Reset
- REQ-033: While rstn = 0 at an edge: FSM = INIT, init_cnt = 0, rd_vld = 0, dout = 0, every pipeline stage = 0, init_done = 0.
- REQ-034: Reset asserted mid-INIT or mid-READY SHALL restart the clear from address 0.
- REQ-035: Reset SHALL drop in-flight reads; no rd_vld pulse SHALL emerge for a read issued before reset.
- REQ-036: Memory contents SHALL NOT be reset directly; they are zeroed only by the INIT sweep.

Configuration
- REQ-037: Macro SA_RAM_WRITE_BYPASS_EN SHALL select collision behaviour (REQ-043 / REQ-044).
- REQ-038: The macro SHALL affect only same-address read/write collisions; all other behaviour SHALL be identical with and without it.
- REQ-043: With SA_RAM_WRITE_BYPASS_EN defined, a read/write collision (re=we=1, ra=wa < DEPTH, READY) SHALL return di (write-first).
- REQ-044: With SA_RAM_WRITE_BYPASS_EN undefined, a read/write collision SHALL return the prior contents (read-first).

Verification
- REQ-039: Scenario: release rstn with DEPTH=64 -> init_done rises exactly 64 cycles later; a read of every address returns 0.
- REQ-040: Scenario: write addr 5 = 0xDEAD_BEEF_0123_4567, then re addr 5 the next cycle -> dout equals that value and rd_vld pulses after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- REQ-041: Scenario: addr 9 holds 0x11, then same-cycle we=re at addr 9 with di=0x22 -> dout=0x22 with the macro, 0x11 without; the next read of addr 9 returns 0x22 in both builds.
- REQ-042: Scenario: DEPTH=48, AW=6, write addr 50 then read addr 50 -> dout=0, rd_vld=1; addr 0..47 are unchanged.
- REQ-045: Scenario: assert rstn=0 for 1 cycle at INIT cycle 30, and again with a read in flight -> init restarts at 0 and takes a full DEPTH cycles; no stale rd_vld appears; dout=0.
- REQ-046: Scenario: re=1 and we=1 every cycle during INIT with wa=ra=3 -> no rd_vld; addr 3 reads 0 after init_done.
